// File: rtl/sw_ctrl.sv
// Stopwatch button front end: synchronise, debounce and edge-detect raw buttons,
// detect long presses, and run the start/split/stop FSM plus a mode selector.
module sw_ctrl #(
  parameter int unsigned N_SW     = 4,
  parameter int unsigned DEB_CNT  = 250000,
  parameter int unsigned LONG_CNT = 50000000,
  parameter int unsigned N_MODES  = 2,
  parameter int unsigned MODE_W   = 1
) (
  input  logic              mclk,
  input  logic              mrst,
  input  logic [N_SW-1:0]   sw,
  output logic              run,
  output logic              rst,
  output logic              sel,
  output logic [MODE_W-1:0] mode,
  output logic [N_SW-1:0]   sw_db,
  output logic [N_SW-1:0]   press,
  output logic [N_SW-1:0]   long_press
);

  localparam int unsigned DebW  = $clog2(DEB_CNT);
  localparam int unsigned LongW = $clog2(LONG_CNT + 1);

  localparam logic [DebW-1:0]   DebLast  = DebW'(DEB_CNT - 1);
  localparam logic [LongW-1:0]  LongMax  = LongW'(LONG_CNT);
  localparam logic [LongW-1:0]  LongPre  = LongW'(LONG_CNT - 1);
  localparam logic [MODE_W-1:0] ModeLast = MODE_W'(N_MODES - 1);

  // State encoding mirrors {run, sel} for readability in waveforms
  typedef enum logic [1:0] {
    StStop      = 2'b00,
    StStopSplit = 2'b01,
    StRun       = 2'b10,
    StSplit     = 2'b11
  } state_e;

  state_e state_q;

  logic [N_SW-1:0]  sync1_q;
  logic [N_SW-1:0]  sync2_q;
  logic [DebW-1:0]  deb_cnt_q  [N_SW];
  logic [LongW-1:0] hold_cnt_q [N_SW];
  logic [N_SW-1:0]  sw_db_dly_q;
  logic             long_seen_q;
  logic             mode_short_q;

  logic ev_clear, ev_start, ev_split, ev_mshort, ev_mlong, mode_zero, stopped;

  // Two-flop synchroniser for the asynchronous button lines
  always_ff @(posedge mclk) begin
    if (mrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: accept s2 only after it has differed for DEB_CNT cycles
  always_ff @(posedge mclk) begin
    if (mrst) begin
      sw_db <= '0;
      for (int i = 0; i < N_SW; i++) deb_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (sync2_q[i] == sw_db[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebLast) begin
          sw_db[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  // Rising-edge press pulses and saturating hold counters for long presses
  always_ff @(posedge mclk) begin
    if (mrst) begin
      sw_db_dly_q <= '0;
      press       <= '0;
      long_press  <= '0;
      for (int i = 0; i < N_SW; i++) hold_cnt_q[i] <= '0;
    end else begin
      sw_db_dly_q <= sw_db;
      press       <= sw_db & ~sw_db_dly_q;
      for (int i = 0; i < N_SW; i++) begin
        long_press[i] <= sw_db[i] && (hold_cnt_q[i] == LongPre);
        if (!sw_db[i]) begin
          hold_cnt_q[i] <= '0;
        end else if (hold_cnt_q[i] != LongMax) begin
          hold_cnt_q[i] <= hold_cnt_q[i] + LongW'(1);
        end
      end
    end
  end

  // Short mode event on release of bit 3, suppressed if that hold went long
  always_ff @(posedge mclk) begin
    if (mrst) begin
      long_seen_q  <= 1'b0;
      mode_short_q <= 1'b0;
    end else begin
      // long_press can still be high in the cycle sw_db falls, so test it directly too
      mode_short_q <= sw_db_dly_q[3] & ~sw_db[3] & ~long_seen_q & ~long_press[3];
      long_seen_q  <= sw_db[3] & (long_seen_q | long_press[3]);
    end
  end

  // Role decoding; stopwatch buttons only count in mode 0
  always_comb begin
    mode_zero = (mode == '0);
    stopped   = (state_q == StStop) || (state_q == StStopSplit);
    ev_clear  = press[1] & mode_zero;
    ev_start  = press[0] & mode_zero;
    ev_split  = press[2] & mode_zero;
    ev_mshort = mode_short_q;
    ev_mlong  = long_press[3];
  end

  // Start/split/stop FSM and mode selector; only the highest-priority event acts
  always_ff @(posedge mclk) begin
    if (mrst) begin
      state_q <= StStop;
      run     <= 1'b0;
      sel     <= 1'b0;
      rst     <= 1'b0;
      mode    <= '0;
    end else begin
      rst <= 1'b0;
      if (ev_clear) begin
        case (state_q)
          StStop: rst <= 1'b1;
          StStopSplit: begin
            state_q <= StStop;
            sel     <= 1'b0;
            rst     <= 1'b1;
          end
          default: ;
        endcase
      end else if (ev_start) begin
        case (state_q)
          StStop: begin
            state_q <= StRun;
            run     <= 1'b1;
          end
          StRun: begin
            state_q <= StStop;
            run     <= 1'b0;
          end
          StSplit: begin
            state_q <= StStopSplit;
            run     <= 1'b0;
          end
          StStopSplit: begin
            state_q <= StSplit;
            run     <= 1'b1;
          end
          default: ;
        endcase
      end else if (ev_split) begin
        case (state_q)
          StRun: begin
            state_q <= StSplit;
            sel     <= 1'b1;
          end
          StSplit: begin
            state_q <= StRun;
            sel     <= 1'b0;
          end
          StStopSplit: begin
            state_q <= StStop;
            sel     <= 1'b0;
          end
          default: ;
        endcase
      end else if (stopped && ev_mlong) begin
        mode <= '0;
      end else if (stopped && ev_mshort) begin
        mode <= (mode == ModeLast) ? '0 : mode + MODE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sw_ctrl.sv
// Bench for sw_ctrl: directed button stimulus, expected output events queued
// by the stimulus and checked by an independent monitor.
module tb_sw_ctrl;

  localparam int unsigned NSw   = 5;
  localparam int unsigned Deb   = 4;
  localparam int unsigned Long  = 16;
  localparam int unsigned Modes = 3;
  localparam int unsigned ModeW = 2;

  logic             mclk = 1'b0;
  logic             mrst = 1'b1;
  logic [NSw-1:0]   sw   = '0;
  logic             run, rst, sel;
  logic [ModeW-1:0] mode;
  logic [NSw-1:0]   sw_db, press, long_press;

  sw_ctrl #(
    .N_SW    (NSw),
    .DEB_CNT (Deb),
    .LONG_CNT(Long),
    .N_MODES (Modes),
    .MODE_W  (ModeW)
  ) dut (
    .mclk      (mclk),
    .mrst      (mrst),
    .sw        (sw),
    .run       (run),
    .rst       (rst),
    .sel       (sel),
    .mode      (mode),
    .sw_db     (sw_db),
    .press     (press),
    .long_press(long_press)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       run;
    logic       sel;
    logic       rst;
    logic [1:0] mode;
    logic [4:0] pr;
    logic [4:0] lp;
    int         due;
    string      name;
  } exp_t;

  exp_t q[$];

  task automatic expect_ev(input string name, input logic r, input logic s, input logic rs,
                           input logic [1:0] m, input logic [4:0] pr, input logic [4:0] lp,
                           input int due);
    exp_t e;
    e.run = r; e.sel = s; e.rst = rs; e.mode = m; e.pr = pr; e.lp = lp;
    e.due = due; e.name = name;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tap(input int idx, input int hold);
    sw[idx] = 1'b1;
    step(hold);
    sw[idx] = 1'b0;
    step(14);
  endtask

  // Monitor: any pulse or change of run/sel/mode is one event to match
  bit         mon_en = 1'b0;
  logic       run_p = 1'b0, sel_p = 1'b0;
  logic [1:0] mode_p = '0;

  always @(negedge mclk) begin
    exp_t e;
    if (mon_en && (press != '0 || long_press != '0 || rst || run != run_p || sel != sel_p ||
                   mode != mode_p)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected event @%0d: run=%0b sel=%0b rst=%0b mode=%0d press=%h lp=%h",
                 cyc, run, sel, rst, mode, press, long_press);
      end else begin
        e = q.pop_front();
        if (run !== e.run || sel !== e.sel || rst !== e.rst || mode !== e.mode ||
            press !== e.pr || long_press !== e.lp || (e.due >= 0 && cyc != e.due)) begin
          errors++;
          $display("FAIL %s @%0d: got run=%0b sel=%0b rst=%0b mode=%0d press=%h lp=%h; want run=%0b sel=%0b rst=%0b mode=%0d press=%h lp=%h due=%0d",
                   e.name, cyc, run, sel, rst, mode, press, long_press,
                   e.run, e.sel, e.rst, e.mode, e.pr, e.lp, e.due);
        end
      end
    end
    run_p  <= run;
    sel_p  <= sel;
    mode_p <= mode;
  end

  initial begin
    int c;
    mrst = 1'b1;
    sw   = '0;
    step(3);
    mrst = 1'b0;
    step(2);
    mon_en = 1'b1;

    // Reset with all buttons held: outputs clear, debounce restarts from zero
    c = cyc;
    sw = 5'h1F;
    mrst = 1'b1;
    step(1);
    mrst = 1'b0;
    chk("reset_outputs", {20'd0, run, rst, sel, mode, press, long_press}, 32'd0);
    chk("reset_sw_db", {27'd0, sw_db}, 32'd0);
    expect_ev("rst_all_press", 0, 0, 0, 2'd0, 5'h1F, 5'h00, c + 8);
    expect_ev("rst_all_clear", 0, 0, 1, 2'd0, 5'h00, 5'h00, c + 9);
    expect_ev("rst_all_long", 0, 0, 0, 2'd0, 5'h00, 5'h1F, -1);
    step(5);
    chk("sw_db_before_accept", {27'd0, sw_db}, 32'd0);
    step(1);
    chk("sw_db_accept", {27'd0, sw_db}, 32'h1F);
    step(25);
    sw = '0;
    step(14);

    // Glitch shorter than DEB_CNT never reaches sw_db
    sw[0] = 1'b1;
    step(3);
    sw[0] = 1'b0;
    step(12);
    chk("glitch_sw_db", {27'd0, sw_db}, 32'd0);
    chk("glitch_run", {31'd0, run}, 32'd0);

    // Clean start press: press then run at DEB_CNT+3 / DEB_CNT+4
    c = cyc;
    expect_ev("start_press", 0, 0, 0, 2'd0, 5'h01, 5'h00, c + Deb + 3);
    expect_ev("start_run", 1, 0, 0, 2'd0, 5'h00, 5'h00, c + Deb + 4);
    tap(0, 6);

    // Split sequence
    expect_ev("split_press", 1, 0, 0, 2'd0, 5'h04, 5'h00, -1);
    expect_ev("split_enter", 1, 1, 0, 2'd0, 5'h00, 5'h00, -1);
    tap(2, 6);
    expect_ev("stop_split_press", 1, 1, 0, 2'd0, 5'h01, 5'h00, -1);
    expect_ev("stop_split", 0, 1, 0, 2'd0, 5'h00, 5'h00, -1);
    tap(0, 6);
    expect_ev("clear_press", 0, 1, 0, 2'd0, 5'h02, 5'h00, -1);
    expect_ev("clear_stop", 0, 0, 1, 2'd0, 5'h00, 5'h00, -1);
    tap(1, 6);

    // Short mode presses wrap 0 -> 1 -> 2 -> 0, then back up to 2
    expect_ev("mode_p1", 0, 0, 0, 2'd0, 5'h08, 5'h00, -1);
    expect_ev("mode_1", 0, 0, 0, 2'd1, 5'h00, 5'h00, -1);
    tap(3, 6);
    expect_ev("mode_p2", 0, 0, 0, 2'd1, 5'h08, 5'h00, -1);
    expect_ev("mode_2", 0, 0, 0, 2'd2, 5'h00, 5'h00, -1);
    tap(3, 6);
    expect_ev("mode_p3", 0, 0, 0, 2'd2, 5'h08, 5'h00, -1);
    expect_ev("mode_wrap", 0, 0, 0, 2'd0, 5'h00, 5'h00, -1);
    tap(3, 6);
    expect_ev("mode_p4", 0, 0, 0, 2'd0, 5'h08, 5'h00, -1);
    expect_ev("mode_1b", 0, 0, 0, 2'd1, 5'h00, 5'h00, -1);
    tap(3, 6);
    expect_ev("mode_p5", 0, 0, 0, 2'd1, 5'h08, 5'h00, -1);
    expect_ev("mode_2b", 0, 0, 0, 2'd2, 5'h00, 5'h00, -1);
    tap(3, 6);

    // Long hold from mode 2 forces mode 0 with no increment on release
    expect_ev("long_press3", 0, 0, 0, 2'd2, 5'h08, 5'h00, -1);
    expect_ev("long_pulse", 0, 0, 0, 2'd2, 5'h00, 5'h08, -1);
    expect_ev("long_mode0", 0, 0, 0, 2'd0, 5'h00, 5'h00, -1);
    tap(3, 20);
    chk("mode_after_long", {30'd0, mode}, 32'd0);

    // Mode button while running is dropped
    expect_ev("run2_press", 0, 0, 0, 2'd0, 5'h01, 5'h00, -1);
    expect_ev("run2_run", 1, 0, 0, 2'd0, 5'h00, 5'h00, -1);
    tap(0, 6);
    expect_ev("run_mode_press", 1, 0, 0, 2'd0, 5'h08, 5'h00, -1);
    tap(3, 6);
    chk("mode_in_run", {30'd0, mode}, 32'd0);
    expect_ev("stop2_press", 1, 0, 0, 2'd0, 5'h01, 5'h00, -1);
    expect_ev("stop2_stop", 0, 0, 0, 2'd0, 5'h00, 5'h00, -1);
    tap(0, 6);

    // Clear and start together: clear wins
    expect_ev("simul_press", 0, 0, 0, 2'd0, 5'h03, 5'h00, -1);
    expect_ev("simul_clear", 0, 0, 1, 2'd0, 5'h00, 5'h00, -1);
    sw = 5'h03;
    step(6);
    sw = '0;
    step(14);
    chk("simul_run", {31'd0, run}, 32'd0);

    // Extra button only pulses press
    expect_ev("sw4_press", 0, 0, 0, 2'd0, 5'h10, 5'h00, -1);
    tap(4, 6);

    // Start in mode 1 is ignored by the FSM
    expect_ev("nz_mode_press", 0, 0, 0, 2'd0, 5'h08, 5'h00, -1);
    expect_ev("nz_mode_1", 0, 0, 0, 2'd1, 5'h00, 5'h00, -1);
    tap(3, 6);
    expect_ev("nz_start_press", 0, 0, 0, 2'd1, 5'h01, 5'h00, -1);
    tap(0, 6);
    chk("nz_run", {31'd0, run}, 32'd0);

    step(10);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_ctrl.md
Name: sw_ctrl

Overview:
- Parametrised successor to the stopwatch switch interface.
- Synchronises, debounces and edge-detects N_SW raw push-buttons, all on mclk; no button line is used as a clock.
- Adds long-press detection, an N_MODES mode selector and a four-state start/split/stop FSM.
- Drives run/rst/sel/mode to the stopwatch counter and display path; also exports per-button press/long-press pulses for other modes.

Parameters:
- N_SW, 4: number of button inputs, must be >= 4. Bits 0..3 have fixed roles; higher bits produce pulses only.
- DEB_CNT, 250000: cycles a synchronised level must stay stable before it is accepted. Must be >= 2.
- LONG_CNT, 50000000: cycles a debounced button must stay held to raise long_press. Must be > DEB_CNT.
- N_MODES, 2: number of modes, must be >= 2. mode counts 0..N_MODES-1.
- MODE_W, 1: width of mode. Must satisfy 2**MODE_W >= N_MODES.

Ports:
- mclk  input  1  system clock.
- mrst  input  1  synchronous active-high reset.
- sw  input  N_SW  raw buttons, active-high, asynchronous to mclk.
- run  output  1  stopwatch counting enable.
- rst  output  1  one-cycle counter-clear pulse.
- sel  output  1  display select: 0 = live time, 1 = frozen split.
- mode  output  MODE_W  current mode.
- sw_db  output  N_SW  debounced button levels.
- press  output  N_SW  one-cycle pulse on each debounced rising edge.
- long_press  output  N_SW  one-cycle pulse when a button has been held LONG_CNT cycles.

Behaviour:
- Reset: one synchronous mrst cycle gives the following.
  - run=0, rst=0, sel=0, mode=0.
  - sw_db=0, press=0, long_press=0.
  - All sync flops and counters at 0; FSM in STOP.
  - mrst mid-press discards all partial debounce and long-press counts.
- Synchroniser: two flops per bit, giving s2.
- Debounce (per bit):
  - The counter increments each cycle s2 != sw_db and clears when s2 == sw_db.
  - When the counter reaches DEB_CNT-1 while s2 still differs, sw_db takes s2 on the next edge and the counter clears.
  - Net effect: a level stable on sw for DEB_CNT+2 cycles reaches sw_db. Any glitch shorter than DEB_CNT cycles never appears.
- press[i]: registered; high for exactly the one cycle after sw_db[i] rises.
- long_press[i]:
  - A hold counter runs while sw_db[i]=1 and clears when sw_db[i]=0.
  - long_press[i] pulses once when the counter reaches LONG_CNT; the counter then saturates.
  - No repeat until the button is released.
- Button roles. Events are derived from press/long_press, so they are 1 cycle after the sw_db change.
  - Bit 0 start/stop: event = press[0].
  - Bit 1 clear: event = press[1].
  - Bit 2 split: event = press[2].
  - Bit 3 mode:
    - Short event fires on the sw_db[3] falling edge, and only if no long_press[3] occurred during that hold.
    - Long event = long_press[3].
- FSM states (run, sel):
  - STOP (0,0)
  - RUN (1,0)
  - SPLIT (1,1)
  - STOP_SPLIT (0,1)
- Start, clear and split are honoured only when mode=0. In other modes they are ignored by the FSM; press still pulses.
- STOP:
  - start → RUN.
  - clear → rst=1 for 1 cycle, stay in STOP.
  - split: ignored.
- RUN:
  - start → STOP.
  - split → SPLIT.
  - clear: ignored.
- SPLIT:
  - start → STOP_SPLIT.
  - split → RUN.
  - clear: ignored.
- STOP_SPLIT:
  - start → SPLIT.
  - split → STOP.
  - clear → STOP, with rst=1 for 1 cycle and sel cleared in the same edge.
- Mode:
  - Acted on only in STOP or STOP_SPLIT.
  - A short mode event makes mode = (mode+1) mod N_MODES, wrapping N_MODES-1 → 0.
  - A long mode event forces mode=0.
  - Mode events in RUN or SPLIT are dropped. They are not queued.
- Simultaneous events in one cycle: only the highest-priority event acts; the rest are dropped. Priority, highest first:
  1. clear
  2. start
  3. split
  4. mode
- Output timing:
  - FSM outputs are registered and update on the edge after the event cycle.
  - Total latency from a stable sw edge to run/sel change is DEB_CNT+4 cycles.
- Widths: counters are sized with clog2 of DEB_CNT and of LONG_CNT+1. No overflow is possible.

Test Plan:
Bench uses DEB_CNT=4, LONG_CNT=16, N_MODES=3, MODE_W=2, N_SW=5.
- Reset: assert mrst for 1 cycle with sw=5'h1F held → all outputs 0 on the next cycle. sw_db rises only DEB_CNT+2 cycles after mrst drops.
- Debounce: 3-cycle pulse on sw[0] → sw_db, press and run stay 0. A 6-cycle hold → press[0] pulses once and run=1 exactly DEB_CNT+4 cycles after the sw edge.
- Split sequence:
  - Steps: start → split → start → clear.
  - Required (run,sel) sequence: (1,0) → (1,1) → (0,1) → (0,0).
  - rst is high for exactly 1 cycle, coinciding with sel returning to 0.
- Mode:
  - In STOP, three short sw[3] presses → mode 1, 2, 0 (wrap).
  - Press, then hold 20 cycles from mode=2 → long_press[3] pulses once, mode=0, and no increment on release.
  - In RUN, a sw[3] press leaves mode unchanged.
- Simultaneous: sw[1] and sw[0] pressed together in STOP → rst pulses once, run stays 0. sw[4] press → only press[4] pulses; FSM unchanged.
- Non-zero mode: with mode=1, press sw[0] → run stays 0 and press[0] pulses once.
